// File: rtl/frame_stack.sv
// Operand stack for the wasm core with a nested call-frame base stack.
// FRAME_LEAVE copies the callee's results down over its frame, one word per cycle.
module frame_stack #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int FRAMES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   op,
  input  logic [WIDTH-1:0]             data,
  input  logic [DEPTH:0]               offset,
  output logic [DEPTH:0]               index,
  output logic [DEPTH:0]               base,
  output logic [$clog2(FRAMES+1)-1:0]  frame_depth,
  output logic [WIDTH-1:0]             out,
  output logic [WIDTH-1:0]             out1,
  output logic [WIDTH-1:0]             out2,
  output logic [WIDTH-1:0]             getter,
  output logic                         busy,
  output logic [1:0]                   status,
  output logic [2:0]                   error
);
  localparam int IW      = DEPTH + 1;
  localparam int FW      = $clog2(FRAMES + 1);
  localparam int FAW     = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int ENTRIES = 1 << DEPTH;

  localparam logic [IW-1:0] ONE       = IW'(1);
  localparam logic [IW-1:0] TWO       = IW'(2);
  localparam logic [IW-1:0] THREE     = IW'(3);
  localparam logic [IW-1:0] ENTRIES_V = IW'(ENTRIES);
  localparam logic [FW-1:0] FRAMES_V  = FW'(FRAMES);

  localparam logic [3:0] OP_PUSH  = 4'd1;
  localparam logic [3:0] OP_POP   = 4'd2;
  localparam logic [3:0] OP_REPL  = 4'd3;
  localparam logic [3:0] OP_BINOP = 4'd4;
  localparam logic [3:0] OP_DUP   = 4'd5;
  localparam logic [3:0] OP_SWAP  = 4'd6;
  localparam logic [3:0] OP_PICK  = 4'd7;
  localparam logic [3:0] OP_ENTER = 4'd8;
  localparam logic [3:0] OP_LEAVE = 4'd9;

  localparam logic [2:0] E_NONE = 3'd0;
  localparam logic [2:0] E_UNF  = 3'd1;
  localparam logic [2:0] E_OVF  = 3'd2;
  localparam logic [2:0] E_BAD  = 3'd3;
  localparam logic [2:0] E_FOVF = 3'd4;
  localparam logic [2:0] E_FUNF = 3'd5;

  typedef enum logic {S_IDLE = 1'b0, S_COPY = 1'b1} state_t;

  state_t            r_state;
  logic [IW-1:0]     r_index, r_base, r_src, r_dst, r_cnt;
  logic [FW-1:0]     r_fd;
  logic [WIDTH-1:0]  r_getter;
  logic [2:0]        r_error;
  logic [WIDTH-1:0]  r_mem    [ENTRIES];
  logic [IW-1:0]     r_bstack [1 << FAW];

  logic [IW-1:0]     w_avail;
  logic [DEPTH-1:0]  w_a0, w_a1, w_a2, w_a3, w_apick;
  logic [2:0]        w_err;
  logic              w_ok;
  logic              w_we_a, w_we_b;
  logic [DEPTH-1:0]  w_addr_a, w_addr_b;
  logic [WIDTH-1:0]  w_wdata_a, w_wdata_b;
  logic              w_frame_push;

  assign w_avail = r_index - r_base;
  assign w_a0    = DEPTH'(r_index);
  assign w_a1    = DEPTH'(r_index - ONE);
  assign w_a2    = DEPTH'(r_index - TWO);
  assign w_a3    = DEPTH'(r_index - THREE);
  assign w_apick = DEPTH'(r_index - ONE - offset);

  always_comb begin
    w_err = E_NONE;
    case (op)
      OP_PUSH:          if (r_index == ENTRIES_V) w_err = E_OVF;
      OP_POP, OP_REPL:  if (w_avail == '0) w_err = E_UNF;
      OP_BINOP, OP_SWAP: if (w_avail < TWO) w_err = E_UNF;
      OP_DUP: begin
        if (w_avail == '0)               w_err = E_UNF;
        else if (r_index == ENTRIES_V)   w_err = E_OVF;
      end
      OP_PICK:          if (offset >= w_avail) w_err = E_BAD;
      OP_ENTER: begin
        if (offset > w_avail)            w_err = E_BAD;
        else if (r_fd == FRAMES_V)       w_err = E_FOVF;
      end
      OP_LEAVE: begin
        if (r_fd == '0)                  w_err = E_FUNF;
        else if (offset > w_avail)       w_err = E_BAD;
      end
      default: ;
    endcase
  end

  assign w_ok         = (r_state == S_IDLE) && (w_err == E_NONE);
  assign w_frame_push = w_ok && (op == OP_ENTER);

  // Memory write ports: port B is only needed for the second half of SWAP.
  always_comb begin
    w_we_a    = 1'b0;
    w_addr_a  = '0;
    w_wdata_a = '0;
    w_we_b    = 1'b0;
    w_addr_b  = '0;
    w_wdata_b = '0;
    if (r_state == S_COPY) begin
      w_we_a    = 1'b1;
      w_addr_a  = DEPTH'(r_dst);
      w_wdata_a = r_mem[DEPTH'(r_src)];
    end else if (w_ok) begin
      case (op)
        OP_PUSH:  begin w_we_a = 1'b1; w_addr_a = w_a0; w_wdata_a = data; end
        OP_REPL:  begin w_we_a = 1'b1; w_addr_a = w_a1; w_wdata_a = data; end
        OP_BINOP: begin w_we_a = 1'b1; w_addr_a = w_a2; w_wdata_a = data; end
        OP_DUP:   begin w_we_a = 1'b1; w_addr_a = w_a0; w_wdata_a = r_mem[w_a1]; end
        OP_SWAP: begin
          w_we_a = 1'b1; w_addr_a = w_a1; w_wdata_a = r_mem[w_a2];
          w_we_b = 1'b1; w_addr_b = w_a2; w_wdata_b = r_mem[w_a1];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we_a) r_mem[w_addr_a] <= w_wdata_a;
    if (w_we_b) r_mem[w_addr_b] <= w_wdata_b;
    if (w_frame_push) r_bstack[FAW'(r_fd)] <= r_base;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_index  <= '0;
      r_base   <= '0;
      r_fd     <= '0;
      r_getter <= '0;
      r_error  <= E_NONE;
      r_src    <= '0;
      r_dst    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_error <= w_err;
          if (w_err == E_NONE) begin
            case (op)
              OP_PUSH, OP_DUP:  r_index  <= r_index + ONE;
              OP_POP, OP_BINOP: r_index  <= r_index - ONE;
              OP_PICK:          r_getter <= r_mem[w_apick];
              OP_ENTER: begin
                r_base <= r_index - offset;
                r_fd   <= r_fd + FW'(1);
              end
              OP_LEAVE: begin
                r_base <= r_bstack[FAW'(r_fd - FW'(1))];
                r_fd   <= r_fd - FW'(1);
                if (offset == '0) begin
                  r_index <= r_base;
                end else begin
                  r_src   <= r_index - offset;
                  r_dst   <= r_base;
                  r_cnt   <= offset;
                  r_state <= S_COPY;
                end
              end
              default: ;
            endcase
          end
        end
        S_COPY: begin
          r_src <= r_src + ONE;
          r_dst <= r_dst + ONE;
          r_cnt <= r_cnt - ONE;
          if (r_cnt == ONE) begin
            r_index <= r_dst + ONE;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign index       = r_index;
  assign base        = r_base;
  assign frame_depth = r_fd;
  assign getter      = r_getter;
  assign error       = r_error;
  assign busy        = (r_state == S_COPY);
  assign status      = (r_index == ENTRIES_V) ? 2'd2 : (r_index == r_base) ? 2'd1 : 2'd0;
  assign out         = (w_avail >= ONE)   ? r_mem[w_a1] : '0;
  assign out1        = (w_avail >= TWO)   ? r_mem[w_a2] : '0;
  assign out2        = (w_avail >= THREE) ? r_mem[w_a3] : '0;
endmodule

// File: doc/frame_stack.md
Name: frame_stack

Overview:
- Parametrised successor to the CPU operand stack for the wasm core.
- Adds a call-frame base stack of configurable depth with frame enter/leave.
- Frame leave copies return values down over the callee frame in a multi-cycle, busy-gated sequence.
- Adds multi-operand ops (binary-op collapse, dup, swap, pick).
- Sits between the decoder/ALU and the value memory; one op is accepted per idle cycle.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 4, log2 of value-stack entries (ENTRIES = 1<<DEPTH).
- FRAMES, 4, maximum nested frames held in the base stack (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous reset, active-low.
- op  in  4  opcode: 0 NOP, 1 PUSH, 2 POP, 3 REPLACE, 4 BINOP (pop 2, push data), 5 DUP, 6 SWAP, 7 PICK, 8 FRAME_ENTER, 9 FRAME_LEAVE; others are NOP.
- data  in  WIDTH  operand for PUSH, REPLACE and BINOP.
- offset  in  DEPTH+1  PICK depth (0 = TOS), ENTER argument count, or LEAVE result count.
- index  out  DEPTH+1  number of live entries.
- base  out  DEPTH+1  current frame base.
- frame_depth  out  $clog2(FRAMES+1)  number of frames entered.
- out, out1, out2  out  WIDTH each  entries index-1, index-2, index-3; each reads 0 when its slot is below base.
- getter  out  WIDTH  PICK result, registered.
- busy  out  1  high while a FRAME_LEAVE copy is in progress.
- status  out  2  0 NONE, 1 EMPTY (index==base), 2 FULL (index==ENTRIES).
- error  out  3  0 NONE, 1 UNDERFLOW, 2 OVERFLOW, 3 BAD_OFFSET, 4 FRAME_OVERFLOW, 5 FRAME_UNDERFLOW.

Behaviour:
- Reset (async, active-low): index, base, frame_depth, getter, error and busy all go to 0, and state goes to IDLE. Memory is not cleared. status goes to EMPTY. out, out1 and out2 read 0.
- Acceptance: an op is accepted on a rising edge in IDLE only. Ops presented while busy=1 are ignored and no error is raised.
- Error register:
  - Updated on every accepted op; valid the cycle after the op.
  - Cleared to NONE by the next accepted op that succeeds.
  - An erroring op changes no other state.
- Live window: entries [base, index) are live. "Available" means index-base.
- Single-cycle ops (effects visible the cycle after acceptance):
  - PUSH: mem[index] <= data; index+1. If index==ENTRIES -> OVERFLOW.
  - POP: index-1. Needs available>=1, else UNDERFLOW.
  - REPLACE: mem[index-1] <= data. Needs available>=1, else UNDERFLOW.
  - BINOP: mem[index-2] <= data; index-1. Needs available>=2, else UNDERFLOW.
  - DUP: mem[index] <= mem[index-1]; index+1. Needs available>=1 (UNDERFLOW) and index<ENTRIES (OVERFLOW). UNDERFLOW takes priority.
  - SWAP: exchanges mem[index-1] and mem[index-2]. Needs available>=2, else UNDERFLOW.
  - PICK: getter <= mem[index-1-offset]. Needs offset<available, else BAD_OFFSET and getter holds its value.
  - FRAME_ENTER:
    - Needs offset<=available (else BAD_OFFSET) and frame_depth<FRAMES (else FRAME_OVERFLOW). BAD_OFFSET takes priority.
    - Pushes base onto the base stack; base <= index-offset; frame_depth+1.
    - index is unchanged; the arguments become the callee's live entries.
- FRAME_LEAVE: multi-cycle FSM with states IDLE, COPY.
  - Needs frame_depth>0 (else FRAME_UNDERFLOW) and offset<=available (else BAD_OFFSET). FRAME_UNDERFLOW takes priority.
  - On acceptance:
    - src <= index-offset, dst <= base, cnt <= offset.
    - base <= popped saved base; frame_depth-1.
    - Results overwrite the callee frame starting at the old base.
  - If cnt==0: index <= dst in the same edge; stay IDLE; busy stays 0.
  - Otherwise go to COPY with busy=1. Each COPY cycle: mem[dst] <= mem[src]; dst+1, src+1, cnt-1.
  - On the cycle cnt reaches 0: index <= final dst; return to IDLE.
  - Total latency: offset+1 edges from acceptance to busy=0.
  - index is frozen during COPY. out, out1 and out2 are undefined while busy=1.
  - When src==dst (callee had no extra entries), copies are idempotent; no special case.
- status is combinational from index, base and ENTRIES. FULL takes priority over EMPTY when base==ENTRIES.
- Reset asserted mid-COPY aborts the copy immediately. All registers return to reset values.
- Arithmetic: index and base are DEPTH+1 bits and never wrap; guards prevent it. Availability compares are unsigned.

Test Plan:
- Reset, then PUSH 0x11, 0x22, 0x33 (DEPTH=2) -> index=3, out=0x33, out1=0x22, out2=0x11, status NONE. PUSH until index=4 -> FULL. Fifth PUSH -> error OVERFLOW, index stays 4.
- PUSH 5, PUSH 7, BINOP data=12 -> index=1, out=12. SWAP -> UNDERFLOW. DUP -> index=2, out=out1=12. PICK offset=1 -> getter=12. PICK offset=2 -> BAD_OFFSET.
- PUSH 1,2,3; FRAME_ENTER offset=2 -> base=1, frame_depth=1, index=3. POP x2 -> EMPTY. Third POP -> UNDERFLOW; index stays 1.
- Frame of base=1 with entries [A,B,C,D] (index=5); FRAME_LEAVE offset=2 -> busy high exactly 2 cycles, then index=3, base=0, out=D, out1=C, out2=mem[0].
- FRAME_LEAVE with frame_depth=0 -> FRAME_UNDERFLOW. FRAMES+1 nested FRAME_ENTER offset=0 -> last returns FRAME_OVERFLOW. PUSH issued during busy -> ignored.
- Assert reset during COPY -> busy=0, index=0, base=0, frame_depth=0, error=0, status EMPTY on the same edge (async).
